// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/bubble control logic:
// operand-unused Tuse code, MDU timer states and default MDU latencies.
package pipe_ctrl_pkg;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam int MULT_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT  = 10;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_busy_timer.sv
// Tracks multiply/divide unit occupancy: a start loads the busy counter,
// which counts down to zero while the unit is producing HI/LO.
module mdu_busy_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic             flush,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] busy_cnt
);

  mdu_state_e state;

  // A flush only cancels a start; a countdown already running keeps going
  // because its HI/LO writeback cannot be recalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= MDU_IDLE;
      busy_cnt <= '0;
    end else if (start && !flush) begin
      state    <= MDU_BUSY;
      busy_cnt <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else begin
      case (state)
        MDU_BUSY: begin
          if (busy_cnt == CNT_W'(1)) begin
            state    <= MDU_IDLE;
            busy_cnt <= '0;
          end else begin
            busy_cnt <= busy_cnt - CNT_W'(1);
          end
        end
        default: begin
          state    <= MDU_IDLE;
          busy_cnt <= '0;
        end
      endcase
    end
  end

  assign mdu_busy = (state == MDU_BUSY) | (start & ~flush);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central stall/bubble controller: Tuse/Tnew data hazards plus MDU occupancy
// drive the PC / IF-ID enables and the ID-EX bubble, with a stall counter.
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT,
  parameter int CNT_W       = 4,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [1:0]        id_tuse_rs,
  input  logic [1:0]        id_tuse_rt,
  input  logic [4:0]        ex_wa,
  input  logic [4:0]        mem_wa,
  input  logic [1:0]        ex_tnew,
  input  logic [1:0]        mem_tnew,
  input  logic              id_md,
  input  logic              ex_start,
  input  logic              ex_is_div,
  input  logic              exc_flush,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_clr,
  output logic              mdu_busy,
  output logic [CNT_W-1:0]  busy_cnt,
  output logic [PERF_W-1:0] stall_cnt
);

  logic haz_rs;
  logic haz_rt;
  logic md_haz;
  logic stall;

  mdu_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .start    (ex_start),
    .is_div   (ex_is_div),
    .flush    (exc_flush),
    .mdu_busy (mdu_busy),
    .busy_cnt (busy_cnt)
  );

  // A producer blocks only if its result is ready later than the consumer needs it.
  assign haz_rs = (id_tuse_rs != TUSE_NONE) && (id_rs != 5'd0) &&
                  (((id_rs == ex_wa)  && (ex_tnew  > id_tuse_rs)) ||
                   ((id_rs == mem_wa) && (mem_tnew > id_tuse_rs)));

  assign haz_rt = (id_tuse_rt != TUSE_NONE) && (id_rt != 5'd0) &&
                  (((id_rt == ex_wa)  && (ex_tnew  > id_tuse_rt)) ||
                   ((id_rt == mem_wa) && (mem_tnew > id_tuse_rt)));

  assign md_haz = id_md & mdu_busy;

  assign stall     = (haz_rs | haz_rt | md_haz) & ~exc_flush;
  assign pc_en     = ~stall;
  assign if_id_en  = ~stall;
  assign id_ex_clr = stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {PERF_W{1'b1}})) begin
      stall_cnt <= stall_cnt + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl; a second instance with
// a 4-bit stall counter exercises saturation.
module tb_hazard_stall_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_wa, mem_wa;
  logic [1:0]  id_tuse_rs, id_tuse_rt, ex_tnew, mem_tnew;
  logic        id_md, ex_start, ex_is_div, exc_flush;
  logic        pc_en, if_id_en, id_ex_clr, mdu_busy;
  logic [3:0]  busy_cnt;
  logic [31:0] stall_cnt;
  logic        s_pc_en, s_if_id_en, s_id_ex_clr, s_mdu_busy;
  logic [3:0]  s_busy_cnt;
  logic [3:0]  s_stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_stall_ctrl dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_tuse_rs(id_tuse_rs), .id_tuse_rt(id_tuse_rt),
    .ex_wa(ex_wa), .mem_wa(mem_wa), .ex_tnew(ex_tnew), .mem_tnew(mem_tnew),
    .id_md(id_md), .ex_start(ex_start), .ex_is_div(ex_is_div), .exc_flush(exc_flush),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_clr(id_ex_clr), .mdu_busy(mdu_busy),
    .busy_cnt(busy_cnt), .stall_cnt(stall_cnt)
  );

  hazard_stall_ctrl #(.PERF_W(4)) dut_sat (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_tuse_rs(id_tuse_rs), .id_tuse_rt(id_tuse_rt),
    .ex_wa(ex_wa), .mem_wa(mem_wa), .ex_tnew(ex_tnew), .mem_tnew(mem_tnew),
    .id_md(id_md), .ex_start(ex_start), .ex_is_div(ex_is_div), .exc_flush(exc_flush),
    .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_ex_clr(s_id_ex_clr), .mdu_busy(s_mdu_busy),
    .busy_cnt(s_busy_cnt), .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_tuse_rs = 2'd3; id_tuse_rt = 2'd3;
    ex_wa = 5'd0; mem_wa = 5'd0; ex_tnew = 2'd0; mem_tnew = 2'd0;
    id_md = 1'b0; ex_start = 1'b0; ex_is_div = 1'b0; exc_flush = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    #3;
    checks++;
    if (pc_en !== 1'b1 || if_id_en !== 1'b1 || id_ex_clr !== 1'b0 || mdu_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got pc_en=%b if_id_en=%b clr=%b busy=%b, want 1 1 0 0",
               pc_en, if_id_en, id_ex_clr, mdu_busy);
    end
    checks++;
    if (busy_cnt !== 4'd0 || stall_cnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_regs: got busy_cnt=%0d stall_cnt=%0d, want 0 0", busy_cnt, stall_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_load_use();
    id_rs = 5'd8; id_tuse_rs = 2'd0; ex_wa = 5'd8; ex_tnew = 2'd1;
    #1;
    checks++;
    if (pc_en !== 1'b0 || if_id_en !== 1'b0 || id_ex_clr !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_use_stall: got pc_en=%b if_id_en=%b clr=%b, want 0 0 1",
               pc_en, if_id_en, id_ex_clr);
    end
    next_cycle();
    ex_wa = 5'd0; ex_tnew = 2'd0; mem_wa = 5'd8; mem_tnew = 2'd0;
    #1;
    checks++;
    if (pc_en !== 1'b1 || id_ex_clr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_use_release: got pc_en=%b clr=%b, want 1 0", pc_en, id_ex_clr);
    end
    // MEM producer still late for an rt consumer needed now.
    id_rs = 5'd0; id_tuse_rs = 2'd3;
    id_rt = 5'd12; id_tuse_rt = 2'd0; mem_wa = 5'd12; mem_tnew = 2'd1;
    #1;
    checks++;
    if (pc_en !== 1'b0 || id_ex_clr !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mem_rt_stall: got pc_en=%b clr=%b, want 0 1", pc_en, id_ex_clr);
    end
    // Tnew equal to Tuse is forwardable in time.
    mem_wa = 5'd0; ex_wa = 5'd12; ex_tnew = 2'd1; id_tuse_rt = 2'd1;
    #1;
    checks++;
    if (pc_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL tnew_eq_tuse: got pc_en=%b, want 1", pc_en);
    end
    ex_tnew = 2'd2;
    #1;
    checks++;
    if (pc_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ex_rt_late: got pc_en=%b, want 0", pc_en);
    end
    exc_flush = 1'b1;
    #1;
    checks++;
    if (pc_en !== 1'b1 || id_ex_clr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_override: got pc_en=%b clr=%b, want 1 0", pc_en, id_ex_clr);
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_zero_unused();
    id_rs = 5'd0; id_tuse_rs = 2'd0; ex_wa = 5'd0; ex_tnew = 2'd2;
    #1;
    checks++;
    if (pc_en !== 1'b1 || id_ex_clr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reg0_no_stall: got pc_en=%b clr=%b, want 1 0", pc_en, id_ex_clr);
    end
    id_tuse_rs = 2'd3;
    id_rt = 5'd9; id_tuse_rt = 2'd3; ex_wa = 5'd9; ex_tnew = 2'd2;
    #1;
    checks++;
    if (pc_en !== 1'b1 || id_ex_clr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL unused_operand: got pc_en=%b clr=%b, want 1 0", pc_en, id_ex_clr);
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_multiply();
    int stalls;
    stalls = 0;
    ex_start = 1'b1; ex_is_div = 1'b0; id_md = 1'b1;
    #1;
    checks++;
    if (mdu_busy !== 1'b1 || pc_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mult_start: got busy=%b pc_en=%b, want 1 0", mdu_busy, pc_en);
    end
    if (pc_en === 1'b0) stalls++;
    next_cycle();
    ex_start = 1'b0;
    #1;
    for (int i = 5; i >= 1; i--) begin
      checks++;
      if (busy_cnt !== 4'(i) || pc_en !== 1'b0) begin
        errors++;
        $display("[TB] FAIL mult_countdown: got busy_cnt=%0d pc_en=%b, want %0d 0", busy_cnt, pc_en, i);
      end
      if (pc_en === 1'b0) stalls++;
      next_cycle();
    end
    checks++;
    if (busy_cnt !== 4'd0 || pc_en !== 1'b1 || mdu_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mult_done: got busy_cnt=%0d pc_en=%b busy=%b, want 0 1 0",
               busy_cnt, pc_en, mdu_busy);
    end
    checks++;
    if (stalls != 6) begin
      errors++;
      $display("[TB] FAIL mult_stall_len: got %0d cycles, want 6", stalls);
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_divide_flush();
    int stalls;
    stalls = 0;
    ex_start = 1'b1; ex_is_div = 1'b1; exc_flush = 1'b1; id_md = 1'b1;
    #1;
    checks++;
    if (mdu_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL div_flush_busy: got %b, want 0", mdu_busy);
    end
    next_cycle();
    ex_start = 1'b0; exc_flush = 1'b0;
    #1;
    checks++;
    if (busy_cnt !== 4'd0 || pc_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL div_flush_cnt: got busy_cnt=%0d pc_en=%b, want 0 1", busy_cnt, pc_en);
    end
    ex_start = 1'b1;
    #1;
    if (pc_en === 1'b0) stalls++;
    next_cycle();
    ex_start = 1'b0;
    #1;
    checks++;
    if (busy_cnt !== 4'd10) begin
      errors++;
      $display("[TB] FAIL div_load: got busy_cnt=%0d, want 10", busy_cnt);
    end
    for (int i = 0; i < 14; i++) begin
      if (pc_en === 1'b0) stalls++;
      next_cycle();
    end
    checks++;
    if (stalls != 11 || busy_cnt !== 4'd0) begin
      errors++;
      $display("[TB] FAIL div_stall_len: got %0d cycles busy_cnt=%0d, want 11 0", stalls, busy_cnt);
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid_divide();
    int guard;
    guard = 0;
    ex_start = 1'b1; ex_is_div = 1'b1;
    next_cycle();
    ex_start = 1'b0;
    #1;
    while (busy_cnt !== 4'd4 && guard < 20) begin
      next_cycle();
      guard++;
    end
    checks++;
    if (guard != 6) begin
      errors++;
      $display("[TB] FAIL div_reach_4: got %0d cycles busy_cnt=%0d, want 6 4", guard, busy_cnt);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (busy_cnt !== 4'd0 || mdu_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: got busy_cnt=%0d busy=%b, want 0 0", busy_cnt, mdu_busy);
    end
    @(negedge clk);
    reset = 1'b1;
    id_md = 1'b1;
    #1;
    checks++;
    if (pc_en !== 1'b1 || mdu_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_md: got pc_en=%b busy=%b, want 1 0", pc_en, mdu_busy);
    end
    next_cycle();
    checks++;
    if (pc_en !== 1'b1 || busy_cnt !== 4'd0) begin
      errors++;
      $display("[TB] FAIL post_reset_md2: got pc_en=%b busy_cnt=%0d, want 1 0", pc_en, busy_cnt);
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_stall_counter();
    do_reset();
    id_rs = 5'd8; id_tuse_rs = 2'd0; ex_wa = 5'd8; ex_tnew = 2'd1;
    for (int i = 0; i < 3; i++) next_cycle();
    idle_inputs();
    next_cycle();
    checks++;
    if (stall_cnt !== 32'd3) begin
      errors++;
      $display("[TB] FAIL stall_cnt_3: got %0d, want 3", stall_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    id_rs = 5'd8; id_tuse_rs = 2'd0; ex_wa = 5'd8; ex_tnew = 2'd1;
    for (int i = 0; i < 14; i++) next_cycle();
    checks++;
    if (s_stall_cnt !== 4'd14) begin
      errors++;
      $display("[TB] FAIL sat_pre: got %0d, want 14", s_stall_cnt);
    end
    for (int i = 0; i < 3; i++) next_cycle();
    idle_inputs();
    checks++;
    if (s_stall_cnt !== 4'd15 || stall_cnt !== 32'd17) begin
      errors++;
      $display("[TB] FAIL sat_hold: got sat=%0d wide=%0d, want 15 17", s_stall_cnt, stall_cnt);
    end
  endtask

  initial begin
    $display("[TB] hazard_stall_ctrl directed tests");
    test_reset();
    test_load_use();
    test_zero_unused();
    test_multiply();
    test_divide_flush();
    test_reset_mid_divide();
    test_stall_counter();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
